mem_responder: RTL
==================

Name: mem_responder

Overview:
- Memory-side responder for the processor datapath's memory interface.
- It accepts the read and write requests that the control unit issues through the address register, the bus_1 data and the write strobe. It services each request after a programmable number of wait states and acknowledges completion with a one-cycle ready pulse.
- It also contains a boot loader that fills memory from a byte stream before normal operation begins.

Parameters:
- WORD_SIZE, 8, data width in bits.
- ADDR_SIZE, 8, address width in bits.
- MEM_DEPTH, 256, number of words; legal range 1..2^ADDR_SIZE.
- WAIT_STATES, 1, extra cycles inserted before a request completes; legal range 0..15.
- BOOT_EN, 1, 1 = start in the boot state after reset, 0 = start in the idle state.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- addr  input  ADDR_SIZE  request address, driven from the address register.
- data_in  input  WORD_SIZE  write data, driven from bus_1.
- write  input  1  write request, level-sampled in IDLE.
- read_req  input  1  read request, level-sampled in IDLE.
- data_out  output  WORD_SIZE  read data, driving the mem_word input of bus_2.
- ready  output  1  one-cycle completion pulse for a read or write.
- addr_err  output  1  pulses together with ready when the completed request had addr >= MEM_DEPTH.
- ld_valid  input  1  boot byte valid.
- ld_data  input  WORD_SIZE  boot byte.
- ld_last  input  1  marks the final boot byte.
- ld_ready  output  1  the block accepts a boot byte this cycle.
- boot_done  output  1  boot has finished; stays high until reset.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to BOOT if BOOT_EN=1, otherwise IDLE.
  - data_out=0, ready=0, addr_err=0, boot_ptr=0, wait counter=0.
  - boot_done = !BOOT_EN.
  - Memory contents are not cleared.
  - A reset asserted mid-request aborts the request: no write is performed and no ready is issued.
- States: BOOT, IDLE, RD_WAIT, WR_WAIT, ACK.
- ld_ready is a registered output, 1 only while in BOOT. It drops to 0 on the edge that accepts the final byte.
- BOOT:
  - A byte is accepted when ld_valid && ld_ready: mem[boot_ptr] <= ld_data and boot_ptr increments.
  - Leave BOOT when the accepted byte has ld_last=1 or boot_ptr == MEM_DEPTH-1.
  - On leaving, go to IDLE and set boot_done=1 on the same edge.
  - read_req and write are ignored in BOOT, and ready stays 0.
  - Bytes presented after boot has finished are ignored.
- IDLE:
  - If write=1: latch addr and data_in, load counter = WAIT_STATES, go to WR_WAIT.
  - Else if read_req=1: latch addr, load counter = WAIT_STATES, go to RD_WAIT.
  - If both are high, write wins.
- RD_WAIT / WR_WAIT:
  - While counter != 0, decrement it.
  - When counter == 0, perform the access on that edge and go to ACK:
    - Read: data_out <= mem[latched addr], or 0 if the address is out of range.
    - Write: mem[latched addr] <= latched data; dropped if the address is out of range.
  - addr_err is set on the same edge if the latched addr >= MEM_DEPTH.
- ACK:
  - ready=1 (and addr_err if flagged) for exactly one cycle, then IDLE.
  - ready and addr_err return to 0 on the exit edge.
- Latency: with the request sampled at edge k, ready is high in the cycle after edge k+WAIT_STATES+1. For WAIT_STATES=0 that is 2 cycles from request to ready.
- Requests that change or arrive outside IDLE are ignored. Inputs are latched, so addr and data_in may change after the sampling edge.
- Back-to-back: a request held high through ACK is re-sampled in IDLE. Minimum request spacing is WAIT_STATES+3 cycles.
- data_out holds the last read value and changes only on read completion.

Test Plan:
- Boot load: BOOT_EN=1, stream 0x51,0x13,0xA0 with ld_last on the third byte. Required: boot_done=1 after the third accept, ld_ready=0. A read of address 2 returns 0xA0.
- Read latency: WAIT_STATES=1, mem[0x10]=0x3C, read_req at edge k. Required: data_out=0x3C and ready=1 in the cycle after edge k+2, ready=0 the next cycle.
- Write then read: write 0x7E to 0x05 (WAIT_STATES=0), then read 0x05. Required: one ready pulse per access; read data_out=0x7E; data_out unchanged during the write.
- Simultaneous write and read_req in IDLE, addr 0x20, data 0x11. Required: a write is performed and a subsequent read returns 0x11. No read completion occurs, and data_out keeps its prior value.
- Out of range: MEM_DEPTH=128, read of 0x90. Required: data_out=0, ready=1 and addr_err=1 together for one cycle. A write to 0x90 alters no location.
- Reset mid-request: assert rst during WR_WAIT with WAIT_STATES=4. Required: state returns to BOOT/IDLE with no ready pulse, the target word is unchanged, and boot_done follows BOOT_EN.

Source files
------------

// File: rtl/mem_responder.sv
// Memory-side responder: services read/write requests after WAIT_STATES wait
// cycles with a one-cycle ready pulse, and fills memory from a boot byte stream.
module mem_responder #(
  parameter int WORD_SIZE   = 8,
  parameter int ADDR_SIZE   = 8,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 1,
  parameter int BOOT_EN     = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_SIZE-1:0] addr,
  input  logic [WORD_SIZE-1:0] data_in,
  input  logic                 write,
  input  logic                 read_req,
  output logic [WORD_SIZE-1:0] data_out,
  output logic                 ready,
  output logic                 addr_err,
  input  logic                 ld_valid,
  input  logic [WORD_SIZE-1:0] ld_data,
  input  logic                 ld_last,
  output logic                 ld_ready,
  output logic                 boot_done
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int AW1   = ADDR_SIZE + 1;

  // Handshakes: a boot byte moves on a rising edge where ld_valid && ld_ready;
  // a request is taken only when seen in IDLE and is answered by one ready pulse.
  typedef enum logic [2:0] {
    S_BOOT    = 3'd0,
    S_IDLE    = 3'd1,
    S_RD_WAIT = 3'd2,
    S_WR_WAIT = 3'd3,
    S_ACK     = 3'd4
  } state_t;

  localparam state_t RESET_STATE = (BOOT_EN != 0) ? S_BOOT : S_IDLE;

  state_t               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic [WORD_SIZE-1:0] wdata_q, wdata_d;
  logic [ADDR_SIZE-1:0] boot_ptr_q, boot_ptr_d;
  logic [WORD_SIZE-1:0] data_out_q, data_out_d;
  logic                 ready_q, ready_d;
  logic                 addr_err_q, addr_err_d;
  logic                 ld_ready_q, ld_ready_d;
  logic                 boot_done_q, boot_done_d;

  logic [WORD_SIZE-1:0] mem [MEM_DEPTH];

  logic                 boot_accept;
  logic                 boot_end;
  logic                 wait_done;
  logic                 addr_in_range;
  logic                 mem_we;
  logic [IDX_W-1:0]     mem_widx;
  logic [WORD_SIZE-1:0] mem_wdata;
  logic [WORD_SIZE-1:0] mem_rdata;

  assign boot_accept   = (state_q == S_BOOT) && ld_valid && ld_ready_q;
  assign boot_end      = boot_accept &&
                         (ld_last || (boot_ptr_q == ADDR_SIZE'(MEM_DEPTH - 1)));
  assign wait_done     = ((state_q == S_RD_WAIT) || (state_q == S_WR_WAIT)) &&
                         (cnt_q == 4'd0);
  assign addr_in_range = ({1'b0, addr_q} < AW1'(MEM_DEPTH));

  // Boot writes and request writes never coincide: they live in different states.
  assign mem_we    = boot_accept ||
                     ((state_q == S_WR_WAIT) && (cnt_q == 4'd0) && addr_in_range);
  assign mem_widx  = boot_accept ? boot_ptr_q[IDX_W-1:0] : addr_q[IDX_W-1:0];
  assign mem_wdata = boot_accept ? ld_data : wdata_q;
  assign mem_rdata = mem[addr_q[IDX_W-1:0]];

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_widx] <= mem_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RESET_STATE;
      cnt_q       <= 4'd0;
      addr_q      <= '0;
      wdata_q     <= '0;
      boot_ptr_q  <= '0;
      data_out_q  <= '0;
      ready_q     <= 1'b0;
      addr_err_q  <= 1'b0;
      ld_ready_q  <= (BOOT_EN != 0);
      boot_done_q <= (BOOT_EN == 0);
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      boot_ptr_q  <= boot_ptr_d;
      data_out_q  <= data_out_d;
      ready_q     <= ready_d;
      addr_err_q  <= addr_err_d;
      ld_ready_q  <= ld_ready_d;
      boot_done_q <= boot_done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_BOOT: begin
        if (boot_end) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (write)         state_d = S_WR_WAIT;
        else if (read_req) state_d = S_RD_WAIT;
      end
      S_RD_WAIT, S_WR_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_ACK;
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = RESET_STATE;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    boot_ptr_d  = boot_ptr_q;
    data_out_d  = data_out_q;
    ready_d     = 1'b0;
    addr_err_d  = 1'b0;
    ld_ready_d  = (state_d == S_BOOT);
    boot_done_d = boot_done_q | boot_end;

    if (boot_accept) begin
      boot_ptr_d = boot_ptr_q + 1'b1;
    end

    // Request inputs are captured once so the control unit may move on.
    if (state_q == S_IDLE && (write || read_req)) begin
      addr_d = addr;
      cnt_d  = 4'(WAIT_STATES);
      if (write) wdata_d = data_in;
    end

    if (((state_q == S_RD_WAIT) || (state_q == S_WR_WAIT)) && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end

    if (wait_done) begin
      ready_d    = 1'b1;
      addr_err_d = !addr_in_range;
      if (state_q == S_RD_WAIT) begin
        data_out_d = addr_in_range ? mem_rdata : '0;
      end
    end
  end

  assign data_out  = data_out_q;
  assign ready     = ready_q;
  assign addr_err  = addr_err_q;
  assign ld_ready  = ld_ready_q;
  assign boot_done = boot_done_q;

endmodule
